store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write FIFO between the EX/MEM pipeline register and the data memory.
//  Stores retire from MEM in one cycle and drain to DMEM in the background.
//  Loads are forwarded from the youngest matching buffered store; otherwise
//  they read DMEM directly. A full buffer raises a stall toward hazard logic.
// PARAMETERS
//  DEPTH  4   number of buffered stores (power of 2, >=2)
//  AW     7   byte-address width, matches the DMEM/PC address width
//  DW     32  data width
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  st_valid   in   1   MEM-stage store request (EX_MEM MemWrite)
//  st_addr    in   AW  store address (ALU result)
//  st_data    in   DW  store data (forwarded rt value)
//  st_stall   out  1   store not accepted this cycle; pipeline must hold
//  ld_valid   in   1   MEM-stage load request (EX_MEM MemRead)
//  ld_addr    in   AW  load address
//  ld_data    out  DW  load result to MEM/WB register
//  ld_hit     out  1   ld_data sourced from the buffer
//  mem_we     out  1   DMEM write strobe (drain)
//  mem_re     out  1   DMEM read strobe (load miss)
//  mem_addr   out  AW  DMEM address
//  mem_wdata  out  DW  DMEM write data
//  mem_rdata  in   DW  DMEM read data, combinational from mem_addr
//  mem_ready  in   1   DMEM accepts write this cycle
//  empty      out  1   no buffered stores (drain-complete indication)
// BEHAVIOUR
//  - Circular FIFO: head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH),
//    count register 0..DEPTH. full = (count==DEPTH), empty = (count==0).
//  - Reset: all valid bits, pointers, count = 0; mem_we=mem_re=0, ld_hit=0,
//    st_stall=0, empty=1, ld_data=mem_rdata. Reset mid-drain drops all entries.
//  - Push: st_valid & !full -> entry written at tail on clk edge, tail++,
//    visible to forwarding the following cycle (latency 1).
//  - st_stall = st_valid & full (combinational). A pop in the same cycle does
//    NOT free space for the push; store retries next cycle.
//  - Load lookup (combinational): compare ld_addr against all valid entries;
//    youngest match (closest to tail) wins. ld_hit=1, ld_data=entry data,
//    mem_re=0. No match: ld_hit=0, mem_re=ld_valid, mem_addr=ld_addr,
//    ld_data=mem_rdata.
//  - Drain FSM, states IDLE / DRAIN:
//    IDLE: empty; mem_we=0. -> DRAIN when count becomes nonzero.
//    DRAIN: mem_we = !(ld_valid & !ld_hit) (load miss owns the port, priority);
//      mem_addr/mem_wdata = head entry. Pop on edge when mem_we & mem_ready:
//      head++, count--. -> IDLE when popping the last entry with no push.
//  - Simultaneous push+pop (not full): count unchanged, both pointers advance.
//  - st_valid & ld_valid together never occurs (single MEM port); if it does,
//    both act independently and the load does not see the same-cycle store.
//  - Entries drain strictly in program order; same-address stores are never
//    reordered.
// CONFIGURATION
//  STORE_BUF_COALESCE_EN defined: a store whose address equals the youngest
//   valid entry's address, and that entry is not being popped this cycle,
//   overwrites that entry's data; no allocation, count unchanged, and it is
//   accepted even when full (st_stall=0).
//  Undefined: every accepted store allocates a new entry.
// TESTING
//  1 Reset mid-drain: 3 entries, mem_ready=0, pulse rst_n -> empty=1,
//    mem_we=0 next cycle, no later DMEM write.
//  2 Store 0x10<-0xDEADBEEF, mem_ready=0, next-cycle load 0x10 -> ld_hit=1,
//    ld_data=0xDEADBEEF, mem_re=0.
//  3 Stores 0x04<-1, 0x04<-2 (coalesce off), load 0x04 -> ld_data=2; drain
//    order: 0x04<-1 then 0x04<-2.
//  4 Fill 4 entries, mem_ready=0, 5th store -> st_stall=1 while held; raise
//    mem_ready -> stall clears the cycle after the first pop.
//  5 Draining with load miss to 0x20 -> mem_we=0, mem_re=1, mem_addr=0x20;
//    drain resumes next cycle.
//  6 COALESCE_EN: full, store to youngest address -> st_stall=0, count stays 4,
//    entry data replaced.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and data memory.
// Stores retire in one cycle and drain to DMEM in program order. Loads are
// forwarded from the youngest matching buffered store; otherwise they read
// DMEM directly and take priority over the drain for the single DMEM port.
// Optional feature macro: STORE_BUF_COALESCE_EN -- a store to the youngest
// entry's address overwrites that entry instead of allocating a new one.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_stall,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_hit,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, DRAIN} state_e;

    logic [AW-1:0]  addr_q [DEPTH];
    logic [DW-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]  head_q, tail_q, head_d, tail_d;
    logic [PW:0]    count_q, count_d;
    state_e         state_q;

    logic           full;
    logic           push, pop, coal;
    logic           load_miss;
    logic           match;
    logic [DW-1:0]  match_data;
    logic [PW-1:0]  youngest;

    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign youngest = tail_q - 1'b1;

    // Youngest-match search: scan oldest to youngest so later hits override.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        match      = 1'b0;
        match_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (addr_q[idx] == ld_addr)) begin
                match      = 1'b1;
                match_data = data_q[idx];
            end
        end
    end

    assign ld_hit    = ld_valid & match;
    assign ld_data   = ld_hit ? match_data : mem_rdata;
    assign load_miss = ld_valid & ~match;

    // A load miss owns the DMEM port; the drain write yields for that cycle.
    assign mem_re    = load_miss;
    assign mem_we    = (state_q == DRAIN) & ~load_miss;
    assign mem_addr  = mem_we ? addr_q[head_q] : ld_addr;
    assign mem_wdata = data_q[head_q];
    assign pop       = mem_we & mem_ready;

`ifdef STORE_BUF_COALESCE_EN
    // Merge into the youngest entry unless that entry leaves this cycle.
    assign coal = st_valid && !empty && valid_q[youngest] &&
                  (addr_q[youngest] == st_addr) &&
                  !(pop && (count_q == (PW+1)'(1)));
`else
    assign coal = 1'b0;
`endif

    // A pop in the same cycle never frees space for a stalled push.
    assign st_stall = st_valid & full & ~coal;
    assign push     = st_valid & ~full & ~coal;

    // Next pointer and occupancy values.
    always_comb begin
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    // Control state: valid bits, pointers, count and drain FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (pop)  valid_q[head_q] <= 1'b0;
            if (push) valid_q[tail_q] <= 1'b1;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            case (state_q)
                IDLE:    if (push) state_q <= DRAIN;
                DRAIN:   if (pop && !push && count_q == (PW+1)'(1)) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Entry storage: written on allocation, data rewritten on coalesce.
    // NOTE: the payload array has no reset; valid_q alone decides whether an
    // entry is live, so stale contents after reset are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
        if (coal) begin
            data_q[youngest] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed, table-driven bench for store_buffer.
// Each table record is one clock cycle: inputs applied after the falling
// edge, outputs compared shortly before the next rising edge.
module tb_store_buffer;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam logic [DW-1:0] RD = 32'h1234_5678;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          st_valid, ld_valid, mem_ready;
    logic [AW-1:0] st_addr, ld_addr, mem_addr;
    logic [DW-1:0] st_data, ld_data, mem_wdata, mem_rdata;
    logic          st_stall, ld_hit, mem_we, mem_re, empty;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .empty(empty)
    );

    typedef struct {
        logic          sv;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic          lv;
        logic [AW-1:0] la;
        logic          rdy;
        logic          e_stall;
        logic          e_hit;
        logic [DW-1:0] e_ld;
        logic          e_we;
        logic          e_re;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_empty;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic lv, input logic [AW-1:0] la, input logic rdy,
                       input logic e_stall, input logic e_hit, input logic [DW-1:0] e_ld,
                       input logic e_we, input logic e_re, input logic [AW-1:0] e_addr,
                       input logic [DW-1:0] e_wdata, input logic e_empty);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la; v.rdy = rdy;
        v.e_stall = e_stall; v.e_hit = e_hit; v.e_ld = e_ld; v.e_we = e_we;
        v.e_re = e_re; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_empty = e_empty;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs and compare the combinational outputs.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        st_valid  = v.sv;  st_addr = v.sa; st_data = v.sd;
        ld_valid  = v.lv;  ld_addr = v.la;
        mem_ready = v.rdy; mem_rdata = RD;
        #2;
        check({tag, ".st_stall"}, DW'(st_stall), DW'(v.e_stall));
        check({tag, ".ld_hit"},   DW'(ld_hit),   DW'(v.e_hit));
        check({tag, ".mem_we"},   DW'(mem_we),   DW'(v.e_we));
        check({tag, ".mem_re"},   DW'(mem_re),   DW'(v.e_re));
        check({tag, ".empty"},    DW'(empty),    DW'(v.e_empty));
        if (v.lv)           check({tag, ".ld_data"},   ld_data,         v.e_ld);
        if (v.e_we || v.e_re) check({tag, ".mem_addr"}, DW'(mem_addr), DW'(v.e_addr));
        if (v.e_we)         check({tag, ".mem_wdata"}, mem_wdata,       v.e_wdata);
    endtask

    initial begin
        // Forwarding of a fresh store, then a single drain.
        add(1, 7'h10, 32'hDEADBEEF, 0, 0,     0, 0, 0, 0,            0, 0, 0,     0,            1);
        add(0, 0,     0,            1, 7'h10, 0, 0, 1, 32'hDEADBEEF, 1, 0, 7'h10, 32'hDEADBEEF, 0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h10, 32'hDEADBEEF, 0);
        // Same-address stores: youngest forwarded, drain in program order.
        add(1, 7'h04, 1,            0, 0,     0, 0, 0, 0,            0, 0, 0,     0,            1);
        add(1, 7'h04, 2,            0, 0,     0, 0, 0, 0,            1, 0, 7'h04, 1,            0);
        add(0, 0,     0,            1, 7'h04, 0, 0, 1, 2,            1, 0, 7'h04, 1,            0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h04, 1,            0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h04, 2,            0);
        // Fill to full; fifth store stalls until the cycle after the first pop.
        add(1, 7'h08, 32'hA1,       0, 0,     0, 0, 0, 0,            0, 0, 0,     0,            1);
        add(1, 7'h0C, 32'hA2,       0, 0,     0, 0, 0, 0,            1, 0, 7'h08, 32'hA1,       0);
        add(1, 7'h10, 32'hA3,       0, 0,     0, 0, 0, 0,            1, 0, 7'h08, 32'hA1,       0);
        add(1, 7'h14, 32'hA4,       0, 0,     0, 0, 0, 0,            1, 0, 7'h08, 32'hA1,       0);
        add(1, 7'h18, 32'hA5,       0, 0,     0, 1, 0, 0,            1, 0, 7'h08, 32'hA1,       0);
        add(1, 7'h18, 32'hA5,       0, 0,     0, 1, 0, 0,            1, 0, 7'h08, 32'hA1,       0);
        add(1, 7'h18, 32'hA5,       0, 0,     1, 1, 0, 0,            1, 0, 7'h08, 32'hA1,       0);
        add(1, 7'h18, 32'hA5,       0, 0,     1, 0, 0, 0,            1, 0, 7'h0C, 32'hA2,       0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h10, 32'hA3,       0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h14, 32'hA4,       0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h18, 32'hA5,       0);
        // Load miss preempts the drain for one cycle; idle miss reads DMEM.
        add(1, 7'h30, 32'h55,       0, 0,     1, 0, 0, 0,            0, 0, 0,     0,            1);
        add(0, 0,     0,            1, 7'h20, 1, 0, 0, RD,           0, 1, 7'h20, 0,            0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h30, 32'h55,       0);
        add(0, 0,     0,            1, 7'h22, 1, 0, 0, RD,           0, 1, 7'h22, 0,            1);
`ifdef STORE_BUF_COALESCE_EN
        // Coalescing into the youngest entry while full.
        add(1, 7'h40, 32'h140,      0, 0,     0, 0, 0, 0,            0, 0, 0,     0,            1);
        add(1, 7'h44, 32'h144,      0, 0,     0, 0, 0, 0,            1, 0, 7'h40, 32'h140,      0);
        add(1, 7'h48, 32'h148,      0, 0,     0, 0, 0, 0,            1, 0, 7'h40, 32'h140,      0);
        add(1, 7'h4C, 32'h14C,      0, 0,     0, 0, 0, 0,            1, 0, 7'h40, 32'h140,      0);
        add(1, 7'h4C, 32'h99,       0, 0,     0, 0, 0, 0,            1, 0, 7'h40, 32'h140,      0);
        add(0, 0,     0,            1, 7'h4C, 0, 0, 1, 32'h99,       1, 0, 7'h40, 32'h140,      0);
        add(1, 7'h50, 32'h150,      0, 0,     0, 1, 0, 0,            1, 0, 7'h40, 32'h140,      0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h40, 32'h140,      0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h44, 32'h144,      0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h48, 32'h148,      0);
        add(0, 0,     0,            0, 0,     1, 0, 0, 0,            1, 0, 7'h4C, 32'h99,       0);
        add(0, 0,     0,            0, 0,     0, 0, 0, 0,            0, 0, 0,     0,            1);
`endif

        // Reset state.
        rst_n = 1'b0;
        st_valid = 0; st_addr = 0; st_data = 0;
        ld_valid = 0; ld_addr = 0; mem_ready = 0; mem_rdata = 32'h0BAD_F00D;
        repeat (2) @(negedge clk);
        #2;
        check("rst.empty",    DW'(empty),    1);
        check("rst.mem_we",   DW'(mem_we),   0);
        check("rst.mem_re",   DW'(mem_re),   0);
        check("rst.st_stall", DW'(st_stall), 0);
        check("rst.ld_hit",   DW'(ld_hit),   0);
        check("rst.ld_data",  ld_data,       32'h0BAD_F00D);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset mid-drain: three held entries must be dropped entirely.
        begin
            vec_t v;
            for (int i = 0; i < 3; i++) begin
                v = '{sv: 1, sa: AW'(7'h60 + 4 * i), sd: DW'(32'h600 + i), lv: 0, la: 0, rdy: 0,
                      e_stall: 0, e_hit: 0, e_ld: 0, e_we: (i != 0), e_re: 0,
                      e_addr: 7'h60, e_wdata: 32'h600, e_empty: (i == 0)};
                run_vec(v, $sformatf("rd%0d", i));
            end
            @(negedge clk);
            st_valid = 0;
            rst_n = 1'b0;
            #1;
            rst_n = 1'b1;
            #1;
            check("rd.empty_after_rst", DW'(empty),  1);
            check("rd.we_after_rst",    DW'(mem_we), 0);
            for (int i = 0; i < 3; i++) begin
                v = '{sv: 0, sa: 0, sd: 0, lv: (i == 0), la: 7'h60, rdy: 1,
                      e_stall: 0, e_hit: 0, e_ld: RD, e_we: 0, e_re: (i == 0),
                      e_addr: 7'h60, e_wdata: 0, e_empty: 1};
                run_vec(v, $sformatf("rdpost%0d", i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
